// File: rtl/faust_hs_pkg.sv
// rtl/faust_hs_pkg.sv - shared types and token-fire helper for Dynamatic kernel drivers
package faust_hs_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_EMIT = 2'd2
  } hs_state_e;

  // A token moves on any clock edge where both valid and ready are high.
  function automatic logic hs_fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/process_driver_if.sv
// rtl/process_driver_if.sv - valid/ready token bundle between driver and process kernel
interface process_driver_if
  import faust_hs_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic [DATA_W-1:0] in0;
  logic              in0_valid;
  logic              in0_ready;
  logic              start_valid;
  logic              start_ready;
  logic [DATA_W-1:0] out0;
  logic              out0_valid;
  logic              out0_ready;
  logic              end_valid;
  logic              end_ready;

  modport master (
    output in0, in0_valid, start_valid, out0_ready, end_ready,
    input  in0_ready, start_ready, out0, out0_valid, end_valid
  );

  modport slave (
    input  in0, in0_valid, start_valid, out0_ready, end_ready,
    output in0_ready, start_ready, out0, out0_valid, end_valid
  );
endinterface

// File: rtl/hs_pending_slot.sv
// rtl/hs_pending_slot.sv - one-entry holding register; a write while full and not read is dropped
module hs_pending_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         overflow
);
  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;
  logic         accept;

  always_comb begin
    // A read in the same cycle frees the slot for the incoming write.
    accept   = wr_en && (!full_q || rd_en);
    full_d   = accept || (full_q && !rd_en);
    data_d   = accept ? wr_data : data_q;
    overflow = wr_en && full_q && !rd_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign rd_data = data_q;
  assign full    = full_q;
endmodule

// File: rtl/process_driver.sv
// rtl/process_driver.sv - runs one process-kernel invocation per sample strobe and emits the result
module process_driver
  import faust_hs_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_strobe,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_out_valid,
  output logic              busy,
  output logic              overrun,
  output logic              timeout,
  output logic [CNT_W-1:0]  done_count,
  process_driver_if.master  kif
);
  localparam int               TMO_W     = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  hs_state_e         state_q, state_d;
  logic [DATA_W-1:0] in0_q, in0_d, result_q, result_d, sample_out_q, sample_out_d;
  logic              sample_out_valid_q, sample_out_valid_d;
  logic              in_sent_q, in_sent_d, start_sent_q, start_sent_d;
  logic              out_got_q, out_got_d, end_got_q, end_got_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d, tmo_inc;
  logic              timeout_q, timeout_d, overrun_q, overrun_d;
  logic [CNT_W-1:0]  done_count_q, done_count_d;

  logic              in_fire, start_fire, out_fire, end_fire, all_done;
  logic              launch, pend_wr, pend_rd, pend_full, pend_ovf;
  logic [DATA_W-1:0] pend_data;

  assign in_fire    = hs_fire(kif.in0_valid, kif.in0_ready);
  assign start_fire = hs_fire(kif.start_valid, kif.start_ready);
  assign out_fire   = hs_fire(kif.out0_valid, kif.out0_ready);
  assign end_fire   = hs_fire(kif.end_valid, kif.end_ready);

  // Pending always launches ahead of a same-cycle strobe, which then takes the slot.
  assign launch  = (state_q != ST_RUN) && (pend_full || sample_strobe);
  assign pend_rd = launch && pend_full;
  assign pend_wr = sample_strobe && ((state_q == ST_RUN) || pend_full);

  hs_pending_slot #(.W(DATA_W)) u_pending (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (pend_wr),
    .wr_data  (sample_in),
    .rd_en    (pend_rd),
    .rd_data  (pend_data),
    .full     (pend_full),
    .overflow (pend_ovf)
  );

  always_comb begin
    state_d            = state_q;
    in0_d              = in0_q;
    result_d           = result_q;
    sample_out_d       = sample_out_q;
    sample_out_valid_d = 1'b0;
    in_sent_d          = in_sent_q;
    start_sent_d       = start_sent_q;
    out_got_d          = out_got_q;
    end_got_d          = end_got_q;
    tmo_cnt_d          = tmo_cnt_q;
    tmo_inc            = tmo_cnt_q + 1'b1;
    timeout_d          = timeout_q;
    overrun_d          = overrun_q | pend_ovf;
    done_count_d       = done_count_q;
    all_done           = (in_sent_q | in_fire) & (start_sent_q | start_fire) &
                         (out_got_q | out_fire) & (end_got_q | end_fire);
    unique case (state_q)
      ST_RUN: begin
        in_sent_d    = in_sent_q | in_fire;
        start_sent_d = start_sent_q | start_fire;
        out_got_d    = out_got_q | out_fire;
        end_got_d    = end_got_q | end_fire;
        if (out_fire) result_d = kif.out0;
        if (tmo_cnt_q != TMO_LIMIT) tmo_cnt_d = tmo_inc;
        if ((TIMEOUT_CYCLES != 0) && (tmo_inc == TMO_LIMIT)) timeout_d = 1'b1;
        if (all_done) begin
          state_d            = ST_EMIT;
          sample_out_d       = out_fire ? kif.out0 : result_q;
          sample_out_valid_d = 1'b1;
        end
      end
      default: begin
        if (state_q == ST_EMIT) done_count_d = done_count_q + 1'b1;
        if (launch) begin
          state_d      = ST_RUN;
          in0_d        = pend_full ? pend_data : sample_in;
          in_sent_d    = 1'b0;
          start_sent_d = 1'b0;
          out_got_d    = 1'b0;
          end_got_d    = 1'b0;
          tmo_cnt_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= ST_IDLE;
      in0_q              <= '0;
      result_q           <= '0;
      sample_out_q       <= '0;
      sample_out_valid_q <= 1'b0;
      in_sent_q          <= 1'b0;
      start_sent_q       <= 1'b0;
      out_got_q          <= 1'b0;
      end_got_q          <= 1'b0;
      tmo_cnt_q          <= '0;
      timeout_q          <= 1'b0;
      overrun_q          <= 1'b0;
      done_count_q       <= '0;
    end else begin
      state_q            <= state_d;
      in0_q              <= in0_d;
      result_q           <= result_d;
      sample_out_q       <= sample_out_d;
      sample_out_valid_q <= sample_out_valid_d;
      in_sent_q          <= in_sent_d;
      start_sent_q       <= start_sent_d;
      out_got_q          <= out_got_d;
      end_got_q          <= end_got_d;
      tmo_cnt_q          <= tmo_cnt_d;
      timeout_q          <= timeout_d;
      overrun_q          <= overrun_d;
      done_count_q       <= done_count_d;
    end
  end

  assign kif.in0         = in0_q;
  assign kif.in0_valid   = (state_q == ST_RUN) && !in_sent_q;
  assign kif.start_valid = (state_q == ST_RUN) && !start_sent_q;
  assign kif.out0_ready  = (state_q == ST_RUN) && !out_got_q;
  assign kif.end_ready   = (state_q == ST_RUN) && !end_got_q;
  assign sample_out       = sample_out_q;
  assign sample_out_valid = sample_out_valid_q;
  assign busy             = state_q != ST_IDLE;
  assign overrun          = overrun_q;
  assign timeout          = timeout_q;
  assign done_count       = done_count_q;
endmodule

// File: tb/tb_process_driver.sv
// tb/tb_process_driver.sv - directed scoreboard bench for process_driver
module tb_process_driver;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] sample_in;
  logic          sample_strobe;
  logic [DW-1:0] sample_out;
  logic          sample_out_valid, busy, overrun, timeout;
  logic [CW-1:0] done_count;

  process_driver_if #(.DATA_W(DW)) kif ();

  process_driver #(.DATA_W(DW), .TIMEOUT_CYCLES(8), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sample_in        (sample_in),
    .sample_strobe    (sample_strobe),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid),
    .busy             (busy),
    .overrun          (overrun),
    .timeout          (timeout),
    .done_count       (done_count),
    .kif              (kif)
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            k_cyc = 0;
  int            in_dly, start_dly, out_dly, end_dly;
  int            exp_lat = -1;
  int            strobe_cyc = 0;
  logic          k_run;
  logic          chk_in0 = 1'b0;
  logic [DW-1:0] chk_in0_val = '0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_k(input int i, input int s, input int o, input int e);
    in_dly = i; start_dly = s; out_dly = o; end_dly = e;
  endtask

  task automatic strobe(input logic [DW-1:0] v, input logic [DW-1:0] e, input bit push);
    sample_in     = v;
    sample_strobe = 1'b1;
    strobe_cyc    = cyc;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    sample_strobe = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, (n < 300), 1);
  endtask

  // Kernel model: out0 = in0 ^ 0x7A, each token offered a fixed number of RUN cycles in.
  always @(negedge clk) begin
    k_run = kif.in0_valid | kif.start_valid | kif.out0_ready | kif.end_ready;
    if (k_run) begin
      kif.in0_ready   = (k_cyc >= in_dly);
      kif.start_ready = (k_cyc >= start_dly);
      kif.out0        = kif.in0 ^ 8'h7A;
      kif.out0_valid  = (k_cyc >= out_dly) && kif.out0_ready;
      kif.end_valid   = (k_cyc >= end_dly) && kif.end_ready;
      k_cyc++;
    end else begin
      kif.in0_ready   = 1'b0;
      kif.start_ready = 1'b0;
      kif.out0        = '0;
      kif.out0_valid  = 1'b0;
      kif.end_valid   = 1'b0;
      k_cyc = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && sample_out_valid) begin
      check("emit_hs_quiet", {kif.in0_valid, kif.start_valid, kif.out0_ready, kif.end_ready}, 0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got 0x%0h, want no output", sample_out);
      end else begin
        exp_v = exp_q.pop_front();
        check("sample_out", sample_out, exp_v);
      end
      if (exp_lat >= 0) begin
        check("latency", cyc - strobe_cyc, exp_lat);
        exp_lat = -1;
      end
    end
    if (chk_in0 && busy) check("in0_stable", kif.in0, chk_in0_val);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    sample_in = '0;
    sample_strobe = 1'b0;
    kif.in0_ready = 1'b0; kif.start_ready = 1'b0; kif.out0 = '0;
    kif.out0_valid = 1'b0; kif.end_valid = 1'b0;
    set_k(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_hs", {kif.in0_valid, kif.start_valid, kif.out0_ready, kif.end_ready}, 0);
    check("rst_flags", {busy, overrun, timeout, sample_out_valid}, 0);
    check("rst_count", done_count, 0);
    check("rst_data", {sample_out, kif.in0}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single sample, all tokens in the first RUN cycle.
    exp_lat = 2;
    strobe(8'h40, 8'h3A, 1);
    wait_idle("t1_idle");
    check("t1_count", done_count, 1);

    // Out-of-order tokens: end first, start last.
    set_k(1, 6, 3, 0);
    chk_in0_val = 8'h81;
    chk_in0 = 1'b1;
    exp_lat = 8;
    strobe(8'h81, 8'hFB, 1);
    wait_idle("t2_idle");
    chk_in0 = 1'b0;
    check("t2_count", done_count, 2);

    // Second strobe lands in RUN, goes to pending, launches from EMIT.
    set_k(0, 0, 1, 0);
    strobe(8'h10, 8'h6A, 1);
    @(negedge clk);
    strobe(8'h20, 8'h5A, 1);
    wait_idle("t3_idle");
    check("t3_count", done_count, 4);
    check("t3_overrun", overrun, 0);

    // Second strobe lands in EMIT with pending empty: direct launch.
    set_k(0, 0, 0, 0);
    strobe(8'h55, 8'h2F, 1);
    @(negedge clk);
    strobe(8'h66, 8'h1C, 1);
    wait_idle("t3b_idle");
    check("t3b_count", done_count, 6);
    check("t3b_overrun", overrun, 0);

    // Overrun: third strobe dropped while pending holds 0x02.
    set_k(0, 0, 5, 0);
    strobe(8'h01, 8'h7B, 1);
    strobe(8'h02, 8'h78, 1);
    strobe(8'h03, 8'h00, 0);
    wait_idle("t4_idle");
    check("t4_overrun", overrun, 1);
    check("t4_count", done_count, 8);
    check("t4_timeout", timeout, 0);

    // Timeout: out0 withheld 20 RUN cycles.
    set_k(0, 0, 20, 0);
    strobe(8'h33, 8'h49, 1);
    repeat (6) @(negedge clk);
    check("t5_timeout_early", timeout, 0);
    repeat (3) @(negedge clk);
    check("t5_timeout_set", timeout, 1);
    wait_idle("t5_idle");
    check("t5_count", done_count, 9);
    check("t5_timeout_sticky", timeout, 1);

    // Reset in the middle of RUN.
    set_k(0, 0, 4, 0);
    strobe(8'h44, 8'h3E, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_hs", {kif.in0_valid, kif.start_valid, kif.out0_ready, kif.end_ready}, 0);
    check("t6_rst_flags", {busy, overrun, timeout, sample_out_valid}, 0);
    check("t6_rst_count", done_count, 0);
    check("t6_rst_data", {sample_out, kif.in0}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_k(0, 0, 0, 0);
    @(negedge clk);
    exp_lat = 2;
    strobe(8'h7F, 8'h05, 1);
    wait_idle("t6_idle");
    check("t6_count", done_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
